// File: rtl/display_pkg.sv
// Shared display-side definitions: screen geometry, bus widths, the plot
// request record and the linear framebuffer address helper.
package display_pkg;

    localparam int SCREEN_W     = 320;
    localparam int SCREEN_H     = 240;
    localparam int X_W          = 9;
    localparam int Y_W          = 8;
    localparam int ADDR_W       = 17;
    localparam int PIX_COLOUR_W = 3;

    typedef struct packed {
        logic [X_W-1:0]          x;
        logic [Y_W-1:0]          y;
        logic [PIX_COLOUR_W-1:0] colour;
    } pixel_req_t;

    // y*320 + x built from two shifts so no multiplier is inferred.
    function automatic logic [ADDR_W-1:0] pixel_addr(input logic [X_W-1:0] x,
                                                     input logic [Y_W-1:0] y);
        logic [ADDR_W-1:0] y_ext;
        logic [ADDR_W-1:0] x_ext;
        y_ext = {{(ADDR_W-Y_W){1'b0}}, y};
        x_ext = {{(ADDR_W-X_W){1'b0}}, x};
        return (y_ext << 8) + (y_ext << 6) + x_ext;
    endfunction

endpackage

// File: rtl/pixel_req_fifo.sv
// Synchronous DEPTH-entry FIFO for plot requests. No bypass: a push into an
// empty FIFO becomes visible at dout one cycle later.
module pixel_req_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      wr_ptr_d;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      rd_ptr_d;
    logic             do_push_s;
    logic             do_pop_s;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign dout      = mem_q[rd_ptr_q[AW-1:0]];
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // Next-state for storage and both pointers.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q[AW-1:0]] = din;
            wr_ptr_d                = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_q <= {(AW+1){1'b0}};
            rd_ptr_q <= {(AW+1){1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/pixel_plot_sink.sv
// Pixel-plot stream sink: FIFO, screen range check, linear address and a
// stallable framebuffer write register. Optional: PIXEL_SINK_TRANSPARENT_EN.
module pixel_plot_sink import display_pkg::*; #(
    parameter int                  DEPTH      = 4,
    parameter int                  COLOUR_W   = PIX_COLOUR_W,
    parameter int                  SCREEN_W   = display_pkg::SCREEN_W,
    parameter int                  SCREEN_H   = display_pkg::SCREEN_H,
    parameter logic [COLOUR_W-1:0] KEY_COLOUR = {COLOUR_W{1'b0}}
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pix_valid,
    input  logic [X_W-1:0]      pix_x,
    input  logic [Y_W-1:0]      pix_y,
    input  logic [COLOUR_W-1:0] pix_colour,
    output logic                pix_ready,
    input  logic                fb_stall,
    output logic                fb_we,
    output logic [ADDR_W-1:0]   fb_addr,
    output logic [COLOUR_W-1:0] fb_data,
    output logic [7:0]          drop_count,
    output logic                idle
);

    localparam int             REQ_W    = X_W + Y_W + COLOUR_W;
    localparam logic [X_W-1:0] X_LIMIT  = X_W'(SCREEN_W);
    localparam logic [Y_W-1:0] Y_LIMIT  = Y_W'(SCREEN_H);
    localparam logic [7:0]     DROP_MAX = 8'd255;

    logic                push_s;
    logic                pop_s;
    logic                advance_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic [REQ_W-1:0]    head_s;
    logic [X_W-1:0]      head_x_s;
    logic [Y_W-1:0]      head_y_s;
    logic [COLOUR_W-1:0] head_colour_s;
    logic                in_range_s;
    logic                key_hit_s;

    logic                fb_we_q;
    logic                fb_we_d;
    logic [ADDR_W-1:0]   fb_addr_q;
    logic [ADDR_W-1:0]   fb_addr_d;
    logic [COLOUR_W-1:0] fb_data_q;
    logic [COLOUR_W-1:0] fb_data_d;
    logic [7:0]          drop_count_q;
    logic [7:0]          drop_count_d;

    // Ready depends only on registered occupancy, so a full FIFO never
    // accepts even when the output stage pops in the same cycle.
    assign pix_ready = !fifo_full_s;
    assign push_s    = pix_valid && !fifo_full_s;
    assign advance_s = !fb_we_q || !fb_stall;
    assign pop_s     = advance_s && !fifo_empty_s;

    pixel_req_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .din   ({pix_x, pix_y, pix_colour}),
        .pop   (pop_s),
        .dout  (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign head_x_s      = head_s[REQ_W-1 -: X_W];
    assign head_y_s      = head_s[COLOUR_W +: Y_W];
    assign head_colour_s = head_s[COLOUR_W-1:0];
    assign in_range_s    = (head_x_s < X_LIMIT) && (head_y_s < Y_LIMIT);

`ifdef PIXEL_SINK_TRANSPARENT_EN
    assign key_hit_s = (head_colour_s == KEY_COLOUR);
`else
    logic unused_key_s;
    assign unused_key_s = &{1'b0, KEY_COLOUR};
    assign key_hit_s    = 1'b0;
`endif

    // Output stage: load from FIFO head, drop/skip, clear, or hold under stall.
    always_comb begin
        fb_we_d      = fb_we_q;
        fb_addr_d    = fb_addr_q;
        fb_data_d    = fb_data_q;
        drop_count_d = drop_count_q;
        if (pop_s) begin
            if (!in_range_s) begin
                fb_we_d = 1'b0;
                if (drop_count_q != DROP_MAX) begin
                    drop_count_d = drop_count_q + 8'd1;
                end else begin
                    drop_count_d = drop_count_q;
                end
            end else if (key_hit_s) begin
                fb_we_d = 1'b0;
            end else begin
                fb_we_d   = 1'b1;
                fb_addr_d = pixel_addr(head_x_s, head_y_s);
                fb_data_d = head_colour_s;
            end
        end else if (advance_s) begin
            fb_we_d = 1'b0;
        end else begin
            fb_we_d = fb_we_q;
        end
    end

    // Output and statistics registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fb_we_q      <= 1'b0;
            fb_addr_q    <= {ADDR_W{1'b0}};
            fb_data_q    <= {COLOUR_W{1'b0}};
            drop_count_q <= 8'd0;
        end else begin
            fb_we_q      <= fb_we_d;
            fb_addr_q    <= fb_addr_d;
            fb_data_q    <= fb_data_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign fb_we      = fb_we_q;
    assign fb_addr    = fb_addr_q;
    assign fb_data    = fb_data_q;
    assign drop_count = drop_count_q;
    assign idle       = fifo_empty_s && !fb_we_q;

endmodule

// File: tb/tb_pixel_plot_sink.sv
// Self-checking bench for pixel_plot_sink: a queue-based model of expected
// writes and drops, plus hand-computed checks for latency, addresses and reset.
module tb_pixel_plot_sink;

    logic        clk = 1'b0;
    logic        reset;
    logic        pix_valid;
    logic [8:0]  pix_x;
    logic [7:0]  pix_y;
    logic [2:0]  pix_colour;
    logic        pix_ready;
    logic        fb_stall;
    logic        fb_we;
    logic [16:0] fb_addr;
    logic [2:0]  fb_data;
    logic [7:0]  drop_count;
    logic        idle;

    pixel_plot_sink dut (
        .clk        (clk),
        .reset      (reset),
        .pix_valid  (pix_valid),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_colour (pix_colour),
        .pix_ready  (pix_ready),
        .fb_stall   (fb_stall),
        .fb_we      (fb_we),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .drop_count (drop_count),
        .idle       (idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int colour;
    } wr_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          writes = 0;
    int          exp_drops = 0;
    wr_t         expq[$];
    logic        hold_pend = 1'b0;
    logic [16:0] hold_addr;
    logic [2:0]  hold_data;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: what the sink must eventually do with one accepted request.
    task automatic model_accept(input int x, input int y, input int c);
        bit keyed;
        keyed = 1'b0;
`ifdef PIXEL_SINK_TRANSPARENT_EN
        keyed = (c == 0);
`endif
        if (x >= 320 || y >= 240) begin
            if (exp_drops < 255) exp_drops++;
        end else if (!keyed) begin
            expq.push_back('{addr: y * 320 + x, colour: c});
        end
    endtask

    // Compare process: stall holding, taken writes, drop count at rest,
    // and recording of accepted requests into the model.
    always @(negedge clk) begin
        if (reset) begin
            hold_pend = 1'b0;
            expq.delete();
            exp_drops = 0;
        end else begin
            if (hold_pend) begin
                chk("hold_we", fb_we, 1);
                chk("hold_addr", fb_addr, hold_addr);
                chk("hold_data", fb_data, hold_data);
            end
            hold_pend = fb_we && fb_stall;
            hold_addr = fb_addr;
            hold_data = fb_data;
            if (fb_we && !fb_stall) begin
                writes++;
                if (expq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_write: got addr %0d data %0d expected no write",
                             fb_addr, fb_data);
                end else begin
                    wr_t e;
                    e = expq.pop_front();
                    chk("write_addr", fb_addr, e.addr);
                    chk("write_data", fb_data, e.colour);
                end
            end
            if (idle) chk("drop_count_model", drop_count, exp_drops);
            if (pix_valid && pix_ready) model_accept(pix_x, pix_y, pix_colour);
        end
    end

    task automatic send(input int x, input int y, input int c);
        pix_x      = 9'(x);
        pix_y      = 8'(y);
        pix_colour = 3'(c);
        pix_valid  = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (pix_ready) begin
                @(posedge clk);
                #1;
                pix_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL send_timeout: got ready 0 for 64 cycles expected ready 1");
        pix_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (idle) return;
            @(posedge clk);
            #1;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL idle_timeout: got idle 0 after %0d cycles expected idle 1", max_cycles);
    endtask

    // Accept at edge N, strobe during the cycle after edge N+1, then idle.
    task automatic single(input int x, input int y, input int c, input int exp_addr);
        send(x, y, c);
        chk("lat_we_early", fb_we, 0);
        @(posedge clk);
        #1;
        chk("lat_we", fb_we, 1);
        chk("lat_addr", fb_addr, exp_addr);
        chk("lat_data", fb_data, c);
        @(posedge clk);
        #1;
        chk("lat_we_after", fb_we, 0);
        chk("lat_idle", idle, 1);
    endtask

    int w0;

    initial begin
        reset      = 1'b1;
        pix_valid  = 1'b0;
        pix_x      = 9'd0;
        pix_y      = 8'd0;
        pix_colour = 3'd0;
        fb_stall   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", pix_ready, 1);
        chk("rst_we", fb_we, 0);
        chk("rst_addr", fb_addr, 0);
        chk("rst_data", fb_data, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_idle", idle, 1);
        reset = 1'b0;
        @(posedge clk);
        #1;

        single(5, 2, 3, 645);

        // Burst under stall: one in the output register plus DEPTH queued.
        fb_stall = 1'b1;
        w0 = writes;
        send(10, 0, 1);
        send(0, 1, 2);
        send(319, 0, 3);
        send(1, 100, 4);
        send(200, 200, 5);
        chk("burst_ready", pix_ready, 0);
        chk("burst_we", fb_we, 1);
        chk("burst_addr", fb_addr, 10);
        repeat (3) @(posedge clk);
        #1;
        chk("burst_stalled_writes", writes - w0, 0);
        fb_stall = 1'b0;
        fork
            send(7, 7, 6);
            for (int k = 1; k <= 6; k++) begin
                @(negedge clk);
                #1;
                chk("burst_rate", writes - w0, k);
            end
        join
        wait_idle(20);
        chk("burst_writes", writes - w0, 6);

        // Screen corners and just-outside coordinates.
        single(319, 239, 1, 76799);
        single(0, 0, 2, 0);
        w0 = writes;
        send(320, 0, 4);
        send(0, 240, 5);
        wait_idle(20);
        chk("oob_no_write", writes - w0, 0);
        chk("oob_drops", drop_count, 2);

        for (int i = 0; i < 300; i++) send(400 + (i % 100), i % 256, i % 8);
        wait_idle(20);
        chk("drop_sat", drop_count, 255);
        for (int i = 0; i < 5; i++) send(5, 250, 1);
        wait_idle(20);
        chk("drop_sat_hold", drop_count, 255);

        // Reset with a stalled strobe and three queued entries.
        fb_stall = 1'b1;
        send(1, 1, 1);
        send(2, 2, 2);
        send(3, 3, 3);
        send(4, 4, 4);
        chk("pre_rst_we", fb_we, 1);
        chk("pre_rst_idle", idle, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_we", fb_we, 0);
        chk("async_rst_ready", pix_ready, 1);
        chk("async_rst_idle", idle, 1);
        chk("async_rst_drop", drop_count, 0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        fb_stall = 1'b0;
        w0 = writes;
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_writes", writes - w0, 0);
        chk("post_rst_idle", idle, 1);

        w0 = writes;
        send(10, 10, 0);
        send(11, 10, 5);
        send(12, 10, 0);
        send(13, 10, 7);
        wait_idle(20);
`ifdef PIXEL_SINK_TRANSPARENT_EN
        chk("key_writes", writes - w0, 2);
`else
        chk("key_writes", writes - w0, 4);
`endif
        chk("key_drops", drop_count, 0);
        chk("final_queue_empty", expq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pixel_plot_sink.md
Name: pixel_plot_sink

Overview:
- Receiving end of the pixel-plot stream that the drawing generators produce (x, y, colour per cycle).
- Buffers incoming plot requests in a small FIFO, range-checks them against the 320x240 screen, and converts (x, y) to a linear framebuffer address.
- Issues single-cycle framebuffer write strobes with backpressure from the framebuffer/VGA adapter side.
- Sits between the display-block multiplexer and the framebuffer memory port.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- COLOUR_W, 3, colour bits per pixel.
- SCREEN_W, 320, valid x range 0..SCREEN_W-1.
- SCREEN_H, 240, valid y range 0..SCREEN_H-1.
- KEY_COLOUR, 0, transparent colour value; used only with the optional feature.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- pix_valid  in  1  plot request present.
- pix_x  in  9  pixel x coordinate.
- pix_y  in  8  pixel y coordinate.
- pix_colour  in  COLOUR_W  pixel colour.
- pix_ready  out  1  sink can accept; transfer occurs when pix_valid & pix_ready at a clock edge.
- fb_stall  in  1  framebuffer cannot take a write this cycle.
- fb_we  out  1  framebuffer write strobe.
- fb_addr  out  17  linear address, y*SCREEN_W + x.
- fb_data  out  COLOUR_W  write colour.
- drop_count  out  8  saturating count of discarded requests.
- idle  out  1  FIFO empty and no write pending.

Behaviour:
- Reset (async, active-high) values:
  - FIFO emptied; pix_ready=1; fb_we=0; fb_addr=0; fb_data=0; drop_count=0; idle=1.
  - Reset mid-operation discards all buffered and pending pixels; no write strobe is emitted after reset asserts.
- Input handshake:
  - pix_ready = !full, derived from registered occupancy only, never from pix_valid.
  - When full, a simultaneous pop does not free a slot for a same-cycle push; pix_ready stays 0 that cycle.
  - No FIFO bypass: a push into an empty FIFO is not visible at the head until the next cycle.
- Output stage: a single register holding fb_we/fb_addr/fb_data.
  - The stage advances (loads from the FIFO head, or clears fb_we if the FIFO is empty) when fb_we==0 or fb_stall==0.
  - While fb_we==1 and fb_stall==1, fb_we, fb_addr and fb_data hold unchanged and no pop occurs.
  - A write is counted as taken on any edge where fb_we==1 and fb_stall==0.
- Latency: pixel accepted at edge N, with the FIFO empty and no stall, gives fb_we=1 during the cycle after edge N+1. Sustained throughput is one pixel per cycle.
- Range check, applied at pop:
  - If pix_x >= SCREEN_W or pix_y >= SCREEN_H, the entry is popped, fb_we loads 0, and drop_count increments.
  - drop_count saturates at 255.
- Address arithmetic:
  - fb_addr = (y<<8) + (y<<6) + x, computed at 17 bits, zero-extended; no multiplier.
  - Maximum in-range address is 76799.
- idle = FIFO empty & !fb_we (registered state only).

Optional Feature:
- Macro PIXEL_SINK_TRANSPARENT_EN.
- Defined: a popped in-range entry whose colour equals KEY_COLOUR is discarded silently. fb_we loads 0 and drop_count is not incremented. Used for sprite overlays.
- Undefined: every in-range entry is written regardless of colour, and KEY_COLOUR is unused.

Decomposition:
- Shared package (display_pkg) holds:
  - SCREEN_W, SCREEN_H, X_W=9, Y_W=8, ADDR_W=17.
  - A packed pixel_req typedef {x, y, colour}.
- One sub-module: pixel_req_fifo, a synchronous DEPTH-entry FIFO with push, pop, full, empty, and async active-high reset.
- Range check, address generation and the output register live in pixel_plot_sink.

Test Plan:
- Single pixel (x=5, y=2, colour=3), no stall -> exactly one fb_we pulse two cycles after acceptance; fb_addr=645; fb_data=3; idle returns to 1.
- Burst of 6 pixels with fb_stall held high -> pix_ready drops after DEPTH+1 accepted; no fb_we changes. Release stall -> 6 writes in order, one per cycle, addresses correct.
- Boundary pixels (319,239) and (0,0) -> addresses 76799 and 0. Pixels (320,0) and (0,240) -> no fb_we; drop_count=2.
- 300 out-of-range pixels -> drop_count saturates at 255 and stays there.
- Assert reset while the FIFO holds 3 entries and fb_we=1 under stall -> fb_we=0 immediately (asynchronously); pix_ready=1; idle=1; nothing written after reset deasserts.
- With PIXEL_SINK_TRANSPARENT_EN defined and KEY_COLOUR=0: pixels with colours 0,5,0,7 -> only colours 5 and 7 written; drop_count=0.
